// File: rtl/occ_lookup_arbiter_pkg.sv
// Shared BWA-MEM definitions for the occurrence-lookup path.
//   KLS_W       : width of a BWT interval bound (k, k+s) and of an occurrence count
//   kls_t       : one bound / count
//   occ_cnt_t   : four counts, index 0..3 = A/C/G/T
//   id_width()  : index width for an N-entry requester set (min 1 bit)
package BwaMemDefines;

  localparam int unsigned KLS_W = 40;

  typedef logic [KLS_W-1:0]      kls_t;
  typedef logic [3:0][KLS_W-1:0] occ_cnt_t;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/occ_lookup_arbiter_if.sv
// Bus bundle between requesters, the arbiter and the occurrence-lookup engine.
//   req_*     : per-requester lookup request (valid/ready, interval bounds)
//   rsp_*     : single response channel back to the winning requester
//   eng_*     : start/complete handshake with the lookup engine
// Modports:
//   slave  : the arbiter side (accepts requests, drives responses and engine)
//   master : the environment side (requesters, response consumer, engine)
interface occ_lookup_arbiter_if
  import BwaMemDefines::*;
#(
  parameter int unsigned N_REQ = 4
) ();

  localparam int unsigned ID_W = id_width(N_REQ);

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ-1:0][KLS_W-1:0] req_k;
  logic [N_REQ-1:0][KLS_W-1:0] req_ks;

  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [ID_W-1:0]             rsp_id;
  occ_cnt_t                    rsp_k;
  occ_cnt_t                    rsp_ks;

  logic                        eng_start;
  kls_t                        eng_k;
  kls_t                        eng_ks;
  logic                        eng_valid;
  occ_cnt_t                    eng_val_k;
  occ_cnt_t                    eng_val_ks;

  modport slave (
    input  req_valid, req_k, req_ks, rsp_ready, eng_valid, eng_val_k, eng_val_ks,
    output req_ready, rsp_valid, rsp_id, rsp_k, rsp_ks, eng_start, eng_k, eng_ks
  );

  modport master (
    output req_valid, req_k, req_ks, rsp_ready, eng_valid, eng_val_k, eng_val_ks,
    input  req_ready, rsp_valid, rsp_id, rsp_k, rsp_ks, eng_start, eng_k, eng_ks
  );

endinterface

// File: rtl/occ_lookup_arbiter_rr_arbiter.sv
// Round-robin selector.
//   req : request vector
//   ptr : highest-priority index this cycle; search proceeds ptr, ptr+1, ... mod N
//   gnt : one-hot grant (all-zero when no request)
//   idx : index of the granted requester (0 when no request)
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  int unsigned c;
  logic        found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      c = (32'(ptr) + i) % N;
      if (!found && req[c[IW-1:0]]) begin
        found            = 1'b1;
        gnt[c[IW-1:0]]   = 1'b1;
        idx              = c[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/occ_lookup_arbiter.sv
// Arbitrates N_REQ occurrence-lookup requesters onto a single lookup engine,
// one lookup outstanding at a time.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : request / response / engine handshakes (slave modport)
//   busy        : high whenever a lookup is in progress (state not IDLE)
//   err_timeout : sticky, set when the engine has not answered within TIMEOUT_CYC
//                 wait cycles; the lookup keeps waiting since the engine cannot abort
module occ_lookup_arbiter
  import BwaMemDefines::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  occ_lookup_arbiter_if.slave  bus,
  output logic                 busy,
  output logic                 err_timeout
);

  localparam int unsigned ID_W  = id_width(N_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q;
  logic [ID_W-1:0]  id_q;
  logic [ID_W-1:0]  win_idx;
  logic [N_REQ-1:0] gnt;
  logic             grant_en;
  kls_t             k_q, ks_q;
  occ_cnt_t         rsp_k_q, rsp_ks_q;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             err_q;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (ID_W)
  ) u_rr (
    .req (bus.req_valid),
    .ptr (rr_ptr_q),
    .gnt (gnt),
    .idx (win_idx)
  );

  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    case (state_q)
      IDLE: begin
        // req_ready is combinational from IDLE, so it must also be held off
        // while reset is asserted.
        if (rst_n && (|bus.req_valid)) begin
          grant_en = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE:   state_d = WAIT;
      WAIT:    if (bus.eng_valid) state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready = grant_en ? gnt : '0;
  assign bus.eng_start = (state_q == ISSUE);
  assign bus.eng_k     = k_q;
  assign bus.eng_ks    = ks_q;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_k     = rsp_k_q;
  assign bus.rsp_ks    = rsp_ks_q;
  assign busy          = (state_q != IDLE);
  assign err_timeout   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      id_q       <= '0;
      k_q        <= '0;
      ks_q       <= '0;
      rsp_k_q    <= '0;
      rsp_ks_q   <= '0;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;

      if (grant_en) begin
        rr_ptr_q <= (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + ID_W'(1);
        id_q     <= win_idx;
        k_q      <= bus.req_k[win_idx];
        ks_q     <= bus.req_ks[win_idx];
      end

      if (state_q == ISSUE) begin
        wait_cnt_q <= '0;
      end

      // Completion takes priority over the timeout reaching its limit in the
      // same cycle; the counter saturates so the flag is set exactly once.
      if (state_q == WAIT) begin
        if (bus.eng_valid) begin
          rsp_k_q  <= bus.eng_val_k;
          rsp_ks_q <= bus.eng_val_ks;
        end else if (wait_cnt_q != CNT_W'(TIMEOUT_CYC)) begin
          wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          if (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            err_q <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: doc/occ_lookup_arbiter.md
OCC_LOOKUP_ARBITER -- requirements
Module: occ_lookup_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters (2..8).
REQ-002 Parameter TIMEOUT_CYC, default 4096: maximum engine wait cycles before the timeout flag sets.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  N_REQ  per-requester lookup request.
REQ-006 req_ready  out  N_REQ  per-requester accept; one-hot or zero.
REQ-007 req_k, req_ks  in  N_REQ x KLS_W  per-requester BWT interval bounds k and k+s.
REQ-008 rsp_valid  out  1  response available.
REQ-009 rsp_ready  in  1  response consumer accept.
REQ-010 rsp_id  out  clog2(N_REQ)  requester index of the current response.
REQ-011 rsp_k, rsp_ks  out  4 x KLS_W  occurrence counts for A/C/G/T at k and at ks.
REQ-012 eng_start  out  1  one-cycle start pulse to the occurrence-lookup engine.
REQ-013 eng_k, eng_ks  out  KLS_W  operands to the engine, stable from eng_start until eng_valid.
REQ-014 eng_valid  in  1  engine one-cycle completion pulse.
REQ-015 eng_val_k, eng_val_ks  in  4 x KLS_W  engine results, valid with eng_valid.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 err_timeout  out  1  sticky; set on engine timeout.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-019 IDLE: if any req_valid, select winner by round-robin from rr_ptr upward (mod N_REQ), assert req_ready[winner] this cycle, latch req_k/req_ks/id, go to ISSUE; otherwise stay.
REQ-020 rr_ptr becomes winner+1 mod N_REQ on each grant; the request is consumed only on the valid&ready cycle.
REQ-021 ISSUE: assert eng_start for exactly one cycle, go to WAIT.
REQ-022 WAIT: on eng_valid, latch all eight counts into rsp_k/rsp_ks, go to RESP; eng_valid in IDLE, ISSUE or RESP is ignored.
REQ-023 WAIT: wait counter saturates at TIMEOUT_CYC; on reaching it, set err_timeout and remain in WAIT (the engine has no abort).
REQ-024 RESP: rsp_valid high with rsp_id/rsp_k/rsp_ks held stable until rsp_ready; on rsp_valid&rsp_ready go to IDLE.
REQ-025 Minimum latency grant-to-rsp_valid = engine latency + 2 cycles; at most one lookup is outstanding.
REQ-026 No new grant in ISSUE, WAIT or RESP; req_ready is all-zero there.
REQ-027 Simultaneous eng_valid and timeout-reach in the same cycle: eng_valid wins and err_timeout does not set.

Reset
REQ-028 On rst_n low, immediately: state IDLE, rr_ptr 0, req_ready 0, eng_start 0, rsp_valid 0, busy 0, err_timeout 0, rsp_id/rsp_k/rsp_ks/eng_k/eng_ks 0.
REQ-029 Reset mid-operation abandons the in-flight lookup; a late eng_valid after reset release is ignored because the state is IDLE.

Structure
REQ-030 KLS_W and a typedef for the 4-entry count array live in BwaMemDefines; the FSM state enum is local.
REQ-031 Round-robin selection is one sub-module rr_arbiter (req vector, pointer -> one-hot grant, index).

Verification
REQ-032 Single request: req_valid[2], k=2, ks=3, engine answers in 32 cycles -> eng_start exactly one cycle, rsp_id=2, eight counts match the engine model, busy drops after rsp_ready.
REQ-033 All four valid continuously from reset -> grants in order 0,1,2,3,0 and never two outstanding.
REQ-034 rsp_ready held low for 20 cycles -> rsp_valid and data stable throughout; no grant until accept.
REQ-035 Engine never answers, TIMEOUT_CYC=64 -> err_timeout sets at wait cycle 64 and stays set; FSM remains in WAIT.
REQ-036 rst_n asserted in WAIT, engine pulses eng_valid 3 cycles after release -> all outputs zero, no rsp_valid.
REQ-037 Boundary operands k=6274909011, ks=6274909012 -> eng_k/eng_ks carry the full 40-bit values unchanged.
